// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and widths for the pipeline stall/flush sequencer and its helpers.
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {CTRL_RUN, CTRL_MDU_WAIT} ctrl_state_t;

    localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the stage registers and the stall/flush/MDU controls driven back to them.
interface pipeline_ctrl_if #(
    parameter int REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W,
    parameter int PERF_W     = 32
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_is_mdu;
    logic                  ex_redirect;
    logic                  mdu_done;

    logic                  stall_if;
    logic                  stall_id;
    logic                  stall_ex;
    logic                  flush_id;
    logic                  flush_ex;
    logic                  mdu_start;
    logic                  mdu_timeout;
    logic [PERF_W-1:0]     stall_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_reg_write,
               ex_mem_read, ex_is_mdu, ex_redirect, mdu_done,
        input  stall_if, stall_id, stall_ex, flush_id, flush_ex, mdu_start,
               mdu_timeout, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_reg_write,
               ex_mem_read, ex_is_mdu, ex_redirect, mdu_done,
        output stall_if, stall_id, stall_ex, flush_id, flush_ex, mdu_start,
               mdu_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl_load_use.sv
// Pure combinational load-use compare between the ID operands and a load sitting in EX.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_reg_write,
    input  logic                  i_ex_mem_read,
    output logic                  o_load_use
);
    logic w_ex_load_wr;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hard-wired zero, so a load targeting it can never create a dependency.
    assign w_ex_load_wr = i_ex_mem_read & i_ex_reg_write & (i_ex_rd != '0);
    assign w_rs1_hit    = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit    = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
    assign o_load_use   = w_ex_load_wr & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: redirect squash, load-use bubble and
// the MDU start/done handshake with a watchdog and a saturating stall-cycle counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MDU_MAX_CYCLES = 40,
    parameter int PERF_W         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    pipeline_ctrl_if.slave  bus
);
    localparam int               WD_W    = (MDU_MAX_CYCLES > 2) ? $clog2(MDU_MAX_CYCLES) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MDU_MAX_CYCLES - 1);
    localparam logic [PERF_W-1:0] CNT_MAX = '1;

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [WD_W-1:0]   r_wdog;
    logic              r_timeout;
    logic [PERF_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_stall_if;
    logic w_stall_id;
    logic w_stall_ex;
    logic w_flush_id;
    logic w_flush_ex;
    logic w_mdu_start;
    logic w_timeout_set;

    load_use_detect u_load_use (
        .i_id_rs1       (bus.id_rs1),
        .i_id_rs2       (bus.id_rs2),
        .i_id_uses_rs1  (bus.id_uses_rs1),
        .i_id_uses_rs2  (bus.id_uses_rs2),
        .i_ex_rd        (bus.ex_rd),
        .i_ex_reg_write (bus.ex_reg_write),
        .i_ex_mem_read  (bus.ex_mem_read),
        .o_load_use     (w_load_use)
    );

    // Outputs are gated by rst_n so an in-flight MDU op is dropped the moment reset asserts.
    always_comb begin
        w_state_nxt   = r_state;
        w_stall_if    = 1'b0;
        w_stall_id    = 1'b0;
        w_stall_ex    = 1'b0;
        w_flush_id    = 1'b0;
        w_flush_ex    = 1'b0;
        w_mdu_start   = 1'b0;
        w_timeout_set = 1'b0;
        if (rst_n) begin
            case (r_state)
                CTRL_RUN: begin
                    if (bus.ex_redirect) begin
                        w_flush_id = 1'b1;
                        w_flush_ex = 1'b1;
                    end else if (bus.ex_is_mdu) begin
                        w_mdu_start = 1'b1;
                        w_stall_if  = 1'b1;
                        w_stall_id  = 1'b1;
                        w_stall_ex  = 1'b1;
                        w_state_nxt = CTRL_MDU_WAIT;
                    end else if (w_load_use) begin
                        w_stall_if  = 1'b1;
                        w_stall_id  = 1'b1;
                        w_flush_ex  = 1'b1;
                    end
                end
                CTRL_MDU_WAIT: begin
                    if (bus.mdu_done) begin
                        w_state_nxt = CTRL_RUN;
                    end else if (r_wdog == WD_LAST) begin
                        // Abort: drop the stuck op from EX and resume fetching.
                        w_flush_ex    = 1'b1;
                        w_timeout_set = 1'b1;
                        w_state_nxt   = CTRL_RUN;
                    end else begin
                        w_stall_if = 1'b1;
                        w_stall_id = 1'b1;
                        w_stall_ex = 1'b1;
                    end
                end
                default: w_state_nxt = CTRL_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= CTRL_RUN;
            r_wdog      <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Held at zero in RUN so the first wait cycle always sees a fresh count.
            if (r_state == CTRL_MDU_WAIT) begin
                r_wdog <= r_wdog + WD_W'(1);
            end else begin
                r_wdog <= '0;
            end
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
            if (w_stall_if && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end
        end
    end

    assign bus.stall_if    = w_stall_if;
    assign bus.stall_id    = w_stall_id;
    assign bus.stall_ex    = w_stall_ex;
    assign bus.flush_id    = w_flush_id;
    assign bus.flush_ex    = w_flush_ex;
    assign bus.mdu_start   = w_mdu_start;
    assign bus.mdu_timeout = r_timeout;
    assign bus.stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: a cycle-level reference model queues expected controls; a negedge
// monitor compares two DUT copies (wide counter and a 3-bit counter that saturates quickly).
module tb_pipeline_ctrl;

    localparam int MAXC = 40;
    localparam int PW_B = 3;
    localparam longint MAX_A = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAX_B = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.PERF_W(32))   if_a ();
    pipeline_ctrl_if #(.PERF_W(PW_B)) if_b ();

    pipeline_ctrl #(.MDU_MAX_CYCLES(MAXC), .PERF_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    pipeline_ctrl #(.MDU_MAX_CYCLES(MAXC), .PERF_W(PW_B)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    assign if_b.id_rs1       = if_a.id_rs1;
    assign if_b.id_rs2       = if_a.id_rs2;
    assign if_b.id_uses_rs1  = if_a.id_uses_rs1;
    assign if_b.id_uses_rs2  = if_a.id_uses_rs2;
    assign if_b.ex_rd        = if_a.ex_rd;
    assign if_b.ex_reg_write = if_a.ex_reg_write;
    assign if_b.ex_mem_read  = if_a.ex_mem_read;
    assign if_b.ex_is_mdu    = if_a.ex_is_mdu;
    assign if_b.ex_redirect  = if_a.ex_redirect;
    assign if_b.mdu_done     = if_a.mdu_done;

    typedef struct packed {
        logic       rn;
        logic       redirect;
        logic       mdu;
        logic       done;
        logic       mem_read;
        logic       reg_write;
        logic       uses1;
        logic       uses2;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } stim_t;

    typedef struct {
        logic [6:0] ctrl;
        longint     cnt_a;
        longint     cnt_b;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: whether an MDU op is outstanding and how long it has waited.
    bit     m_busy   = 1'b0;
    int     m_waited = 0;
    bit     m_to     = 1'b0;
    longint m_cnt_a  = 0;
    longint m_cnt_b  = 0;

    task automatic step(input stim_t s, input string tag);
        bit   lu, sif, sid, sex, fid, fex, st;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n             = s.rn;
        if_a.ex_redirect  = s.redirect;
        if_a.ex_is_mdu    = s.mdu;
        if_a.mdu_done     = s.done;
        if_a.ex_mem_read  = s.mem_read;
        if_a.ex_reg_write = s.reg_write;
        if_a.id_uses_rs1  = s.uses1;
        if_a.id_uses_rs2  = s.uses2;
        if_a.ex_rd        = s.rd;
        if_a.id_rs1       = s.rs1;
        if_a.id_rs2       = s.rs2;

        lu = s.mem_read && s.reg_write && (s.rd != 0) &&
             ((s.uses1 && (s.rs1 == s.rd)) || (s.uses2 && (s.rs2 == s.rd)));
        {sif, sid, sex, fid, fex, st} = '0;
        e.cnt_a = m_cnt_a;
        e.cnt_b = m_cnt_b;
        e.tag   = tag;
        e.ctrl  = '0;
        e.ctrl[0] = m_to;

        if (!s.rn) begin
            m_busy   = 1'b0;
            m_waited = 0;
            m_to     = 1'b0;
            m_cnt_a  = 0;
            m_cnt_b  = 0;
        end else begin
            if (!m_busy) begin
                if (s.redirect) begin
                    fid = 1'b1;
                    fex = 1'b1;
                end else if (s.mdu) begin
                    st = 1'b1;
                    {sif, sid, sex} = 3'b111;
                    m_busy   = 1'b1;
                    m_waited = 0;
                end else if (lu) begin
                    sif = 1'b1;
                    sid = 1'b1;
                    fex = 1'b1;
                end
            end else begin
                if (s.done) begin
                    m_busy = 1'b0;
                end else if (m_waited == MAXC - 1) begin
                    fex    = 1'b1;
                    m_to   = 1'b1;
                    m_busy = 1'b0;
                end else begin
                    {sif, sid, sex} = 3'b111;
                    m_waited++;
                end
            end
            if (sif) begin
                if (m_cnt_a < MAX_A) m_cnt_a++;
                if (m_cnt_b < MAX_B) m_cnt_b++;
            end
        end
        e.ctrl[6:1] = {sif, sid, sex, fid, fex, st};
        sb_q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s    = '0;
        s.rn = 1'b1;
        return s;
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t       e;
            logic [6:0] got_a, got_b;
            longint     cnt_a, cnt_b;
            e     = sb_q.pop_front();
            got_a = {if_a.stall_if, if_a.stall_id, if_a.stall_ex, if_a.flush_id,
                     if_a.flush_ex, if_a.mdu_start, if_a.mdu_timeout};
            got_b = {if_b.stall_if, if_b.stall_id, if_b.stall_ex, if_b.flush_id,
                     if_b.flush_ex, if_b.mdu_start, if_b.mdu_timeout};
            cnt_a = longint'(if_a.stall_count);
            cnt_b = longint'(if_b.stall_count);
            n_tests++;
            if (got_a !== e.ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl_a got %b want %b (if id ex fid fex start to)", e.tag, got_a, e.ctrl);
            end
            n_tests++;
            if (got_b !== e.ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl_b got %b want %b", e.tag, got_b, e.ctrl);
            end
            n_tests++;
            if (cnt_a != e.cnt_a) begin
                n_fail++;
                $display("FAIL %s stall_count got %0d want %0d", e.tag, cnt_a, e.cnt_a);
            end
            n_tests++;
            if (cnt_b != e.cnt_b) begin
                n_fail++;
                $display("FAIL %s stall_count_sat got %0d want %0d", e.tag, cnt_b, e.cnt_b);
            end
        end
    end

    initial begin
        stim_t s;
        if_a.ex_redirect  = 1'b0;
        if_a.ex_is_mdu    = 1'b0;
        if_a.mdu_done     = 1'b0;
        if_a.ex_mem_read  = 1'b0;
        if_a.ex_reg_write = 1'b0;
        if_a.id_uses_rs1  = 1'b0;
        if_a.id_uses_rs2  = 1'b0;
        if_a.ex_rd        = '0;
        if_a.id_rs1       = '0;
        if_a.id_rs2       = '0;
        rst_n             = 1'b0;
        repeat (2) @(posedge clk);

        s = '0;
        step(s, "reset");
        step(idle(), "idle");

        // Load-use on rs1, then rs2, then the same pattern targeting x0.
        s = idle(); s.mem_read = 1; s.reg_write = 1; s.rd = 5; s.rs1 = 5; s.uses1 = 1;
        step(s, "lu_rs1");
        s.rs1 = 7; s.rs2 = 5; s.uses2 = 1; s.uses1 = 0;
        step(s, "lu_rs2");
        s.rd = 0; s.rs2 = 0;
        step(s, "lu_x0");
        s.rd = 5; s.rs2 = 5; s.uses2 = 0;
        step(s, "lu_unused");

        // Redirect wins over a simultaneous load-use and MDU op.
        s = idle(); s.mem_read = 1; s.reg_write = 1; s.rd = 9; s.rs1 = 9; s.uses1 = 1; s.redirect = 1;
        step(s, "redir_lu");
        s.mdu = 1;
        step(s, "redir_mdu");

        // MDU with done on the 4th wait cycle, counted from a fresh reset.
        s = '0; step(s, "rst_mdu");
        s = idle(); s.mdu = 1;
        step(s, "mdu_start");
        for (int i = 0; i < 3; i++) step(s, "mdu_wait");
        s.done = 1; s.redirect = 1;
        step(s, "mdu_done");
        step(idle(), "mdu_after");

        // Watchdog: no done ever, stray redirects/load-use ignored while waiting.
        s = '0; step(s, "rst_wd");
        s = idle(); s.mdu = 1;
        step(s, "wd_start");
        s.mdu = 0; s.redirect = 1; s.mem_read = 1; s.reg_write = 1; s.rd = 3; s.rs1 = 3; s.uses1 = 1;
        for (int i = 0; i < MAXC; i++) step(s, "wd_wait");
        for (int i = 0; i < 3; i++) step(idle(), "wd_sticky");

        // Reset mid-wait abandons the op; no relaunch until ex_is_mdu returns.
        s = idle(); s.mdu = 1;
        step(s, "rw_start");
        step(s, "rw_wait");
        step(s, "rw_wait");
        s.rn = 0; s.done = 1;
        step(s, "rw_reset");
        for (int i = 0; i < 3; i++) step(idle(), "rw_idle");
        s = idle(); s.mdu = 1;
        step(s, "rw_relaunch");
        s.done = 1;
        step(s, "rw_done");

        for (int i = 0; i < 3000; i++) begin
            s           = '0;
            s.rn        = ($urandom_range(0, 80) != 0);
            s.redirect  = ($urandom_range(0, 7) == 0);
            s.mdu       = ($urandom_range(0, 9) == 0);
            s.done      = ($urandom_range(0, 4) == 0);
            s.mem_read  = ($urandom_range(0, 1) == 1);
            s.reg_write = ($urandom_range(0, 3) != 0);
            s.uses1     = ($urandom_range(0, 1) == 1);
            s.uses2     = ($urandom_range(0, 1) == 1);
            s.rd        = 5'($urandom_range(0, 3));
            s.rs1       = 5'($urandom_range(0, 3));
            s.rs2       = 5'($urandom_range(0, 3));
            step(s, "rand");
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
